dot11_tx_run_seq: RTL and testbench
===================================

# dot11_tx_run_seq

Synthesizable multi-run sequencer for `dot11_tx`. It drives the PHY's reset and start, waits for completion or timeout, and repeats for a parametrised number of transmissions. Every output IQ sample is tagged with its run index and each run's samples are counted. It sits between the TX control logic (or a self-test harness) and `dot11_tx`, and replaces hand-sequenced reset/start stimulus.

## Interface
- `NUM_RUNS`, 3: transmissions per `go`, at least 1.
- `RUN_W`, 4: width of the run index; must satisfy 2^RUN_W ≥ NUM_RUNS.
- `GAP_CYCLES`, 4: cycles `phy_tx_arest` is held high before each run, at least 1.
- `START_CYCLES`, 5: cycles `phy_tx_start` is held high, at least 1.
- `TIMEOUT_CYCLES`, 2140: cycles allowed in WAIT before a timeout, at least 1.
- `IQ_W`, 16: I/Q sample width.
- `CNT_W`, 16: sample counter width.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `go` in 1: one-cycle request to start a sequence; honoured only in IDLE.
- `abort` in 1: return to IDLE from any state.
- `phy_tx_arest` out 1: PHY reset, active high.
- `phy_tx_start` out 1: PHY start.
- `phy_tx_done` in 1: PHY end-of-transmission.
- `phy_tx_started` in 1: PHY started indication.
- `iq_valid_in` in 1: PHY sample valid.
- `i_in` in IQ_W signed: PHY I sample.
- `q_in` in IQ_W signed: PHY Q sample.
- `iq_valid_out` out 1: tagged sample valid.
- `i_out` out IQ_W signed: tagged I sample.
- `q_out` out IQ_W signed: tagged Q sample.
- `iq_run` out RUN_W: run index of the current output sample.
- `run_idx` out RUN_W: run currently in progress.
- `run_done` out 1: one-cycle pulse at the end of each run.
- `run_samples` out CNT_W: sample count of the last finished run.
- `busy` out 1: high in every state except IDLE and FINISH.
- `all_done` out 1: high in FINISH.
- `timeout_err` out 1: sticky; set by any timed-out run.
- `started_seen` out 1: sticky per run; set when `phy_tx_started` has been seen.

## Operation
- States and transitions:
  - IDLE: `go` → RST. Clears `run_idx`, `timeout_err`, the counters and `started_seen`.
  - RST: `phy_tx_arest`=1 for GAP_CYCLES → START.
  - START: `phy_tx_start`=1, `phy_tx_arest`=0, for START_CYCLES → WAIT.
  - WAIT: `phy_tx_done` → NEXT. Timer reaches TIMEOUT_CYCLES → NEXT, and `timeout_err` is set.
  - NEXT: pulses `run_done` and latches `run_samples`. If `run_idx`==NUM_RUNS-1 → FINISH; otherwise `run_idx`+1 → RST.
  - FINISH: `all_done`=1 and `phy_tx_arest`=1; `go` → RST as a fresh sequence.
- `phy_tx_arest` is 1 in IDLE, RST, NEXT and FINISH. The PHY is held in reset whenever it is not transmitting.
- `phy_tx_done` is also accepted in START; this skips the rest of START and goes to NEXT.
- Done and timeout in the same cycle: done wins, and `timeout_err` is not set.
- `abort` in any state → IDLE on the next edge. No `run_done` pulse; `run_samples` and `timeout_err` hold their values; `abort` has priority over all other events.
- `go` outside IDLE and FINISH is ignored.
- IQ samples are forwarded only in START and WAIT; samples arriving in any other state are dropped and not counted.
- The sample counter saturates at 2^CNT_W−1 and is cleared on entry to RST.

## Timing
- Reset values: `phy_tx_arest`=1; all other outputs 0. State is IDLE.
- `go` at edge 0: RST occupies edges 1..GAP_CYCLES; START occupies the next START_CYCLES edges; WAIT follows.
- `phy_tx_done` sampled at edge n in WAIT: NEXT at n+1, with `run_done`=1 during that cycle.
- IQ path is one register stage. `iq_valid_out`, `i_out`, `q_out` and `iq_run` appear 1 cycle after the inputs. A sample captured in WAIT's last cycle is still emitted.
- `run_samples` is valid in the same cycle as the `run_done` pulse and is held until the next `run_done` or reset.
- The timeout timer counts WAIT cycles only and restarts in every run.

## Structure
- Package `dot11_tx_run_seq_pkg` holds:
  - the state enum (IDLE, RST, START, WAIT, NEXT, FINISH);
  - the default parameter constants.
- Sub-module `dot11_tx_iq_tap` holds:
  - the IQ register stage;
  - the run-index tagging;
  - the saturating sample counter.
- The FSM and timers live in the top level.

## Test plan
- Three clean runs, PHY model with 100 samples and done 300 cycles after start → 3 `run_done` pulses, `run_samples`=100 each, `iq_run` 0,1,2, `all_done`=1, `timeout_err`=0.
- PHY never asserts done in run 1 (of 0..2) → `timeout_err`=1 exactly 2140 WAIT cycles after run 1 START ends; run 2 proceeds normally.
- `abort` mid-WAIT in run 1 → IDLE next cycle, `phy_tx_arest`=1, no `run_done`, `run_samples` stays 100.
- Done and timeout in the same cycle → NEXT, `timeout_err`=0.
- Samples from the PHY while in RST → `iq_valid_out` stays 0 and the count is unchanged; CNT_W=4 with 20 samples → `run_samples`=15.
- `rstn` low during START → outputs at reset values immediately, with no clock edge needed; `go` after release → run 0 restarts.

Source files
------------

// File: rtl/dot11_tx_run_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dot11_tx_run_seq_pkg
// Brief    : Shared state encoding and default parameters for the dot11_tx
//            multi-run sequencer and its IQ tap.
// Revision : 1.0 - initial release
// ============================================================================
package dot11_tx_run_seq_pkg;

   // Sequencer states; explicit encoding keeps netlists readable.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST    = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } run_state_e;

   localparam int DEF_NUM_RUNS       = 3;
   localparam int DEF_RUN_W          = 4;
   localparam int DEF_GAP_CYCLES     = 4;
   localparam int DEF_START_CYCLES   = 5;
   localparam int DEF_TIMEOUT_CYCLES = 2140;
   localparam int DEF_IQ_W           = 16;
   localparam int DEF_CNT_W          = 16;

   // Largest of three cycle limits; sizes the shared phase timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dot11_tx_iq_tap.sv
`default_nettype none
// ============================================================================
// Module   : dot11_tx_iq_tap
// Brief    : One-stage IQ register that tags each forwarded sample with the
//            current run index and keeps a saturating per-run sample count.
// Revision : 1.0 - initial release
// ============================================================================
module dot11_tx_iq_tap #(
   parameter int IQ_W  = 16,
   parameter int RUN_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    accept_en,
   input  logic                    cnt_clr,
   input  logic [RUN_W-1:0]        run_idx,
   input  logic                    iq_valid_in,
   input  logic signed [IQ_W-1:0]  i_in,
   input  logic signed [IQ_W-1:0]  q_in,
   output logic                    iq_valid_out,
   output logic signed [IQ_W-1:0]  i_out,
   output logic signed [IQ_W-1:0]  q_out,
   output logic [RUN_W-1:0]        iq_run,
   output logic [CNT_W-1:0]        cnt_next
);

   logic                   take;
   logic                   valid_d, valid_q;
   logic signed [IQ_W-1:0] i_d, i_q, q_d, q_q;
   logic [RUN_W-1:0]       tag_d, tag_q;
   logic [CNT_W-1:0]       cnt_d, cnt_q;

   assign take = iq_valid_in & accept_en;

   // Next-state for the sample register, tag and saturating counter.
   always_comb begin
      valid_d = take;
      i_d     = i_q;
      q_d     = q_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      if (take) begin
         i_d   = i_in;
         q_d   = q_in;
         tag_d = run_idx;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (take && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Register stage; all state returns to zero under reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         i_q     <= '0;
         q_q     <= '0;
         tag_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         i_q     <= i_d;
         q_q     <= q_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign iq_valid_out = valid_q;
   assign i_out        = i_q;
   assign q_out        = q_q;
   assign iq_run       = tag_q;
   // Next count so a sample taken on the run's final edge is included.
   assign cnt_next     = cnt_d;

endmodule
`default_nettype wire

// File: rtl/dot11_tx_run_seq.sv
`default_nettype none
// ============================================================================
// Module   : dot11_tx_run_seq
// Brief    : Multi-run sequencer for dot11_tx: drives PHY reset/start, waits
//            for done or timeout, repeats NUM_RUNS times, tags IQ output.
// Revision : 1.0 - initial release
// ============================================================================
module dot11_tx_run_seq
   import dot11_tx_run_seq_pkg::*;
#(
   parameter int NUM_RUNS       = DEF_NUM_RUNS,
   parameter int RUN_W          = DEF_RUN_W,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int START_CYCLES   = DEF_START_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int IQ_W           = DEF_IQ_W,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    go,
   input  logic                    abort,
   output logic                    phy_tx_arest,
   output logic                    phy_tx_start,
   input  logic                    phy_tx_done,
   input  logic                    phy_tx_started,
   input  logic                    iq_valid_in,
   input  logic signed [IQ_W-1:0]  i_in,
   input  logic signed [IQ_W-1:0]  q_in,
   output logic                    iq_valid_out,
   output logic signed [IQ_W-1:0]  i_out,
   output logic signed [IQ_W-1:0]  q_out,
   output logic [RUN_W-1:0]        iq_run,
   output logic [RUN_W-1:0]        run_idx,
   output logic                    run_done,
   output logic [CNT_W-1:0]        run_samples,
   output logic                    busy,
   output logic                    all_done,
   output logic                    timeout_err,
   output logic                    started_seen
);

   localparam int TMR_MAX = max3(GAP_CYCLES, START_CYCLES, TIMEOUT_CYCLES);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] C_GAP_LAST   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0] C_START_LAST = TMR_W'(START_CYCLES - 1);
   localparam logic [TMR_W-1:0] C_TO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RUN_W-1:0] C_LAST_RUN   = RUN_W'(NUM_RUNS - 1);

   run_state_e       state_d, state_q;
   logic [TMR_W-1:0] timer_d, timer_q;
   logic [RUN_W-1:0] run_idx_d, run_idx_q;
   logic [CNT_W-1:0] run_samples_d, run_samples_q;
   logic             run_done_d, run_done_q;
   logic             timeout_err_d, timeout_err_q;
   logic             started_seen_d, started_seen_q;
   logic             arest_d, arest_q;
   logic             start_d, start_q;
   logic             busy_d, busy_q;
   logic             all_done_d, all_done_q;
   logic             accept_en;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_next;

   // Samples are only meaningful while the PHY is out of reset.
   assign accept_en = (state_q == S_START) || (state_q == S_WAIT);

   // Sample counter clears whenever the FSM is about to enter RST.
   assign cnt_clr = !abort &&
                    ((((state_q == S_IDLE) || (state_q == S_FINISH)) && go) ||
                     ((state_q == S_NEXT) && (run_idx_q != C_LAST_RUN)));

   // FSM next-state, phase timer, run bookkeeping and registered outputs.
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q + TMR_W'(1);
      run_idx_d      = run_idx_q;
      run_samples_d  = run_samples_q;
      timeout_err_d  = timeout_err_q;
      started_seen_d = started_seen_q;
      run_done_d     = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_FINISH: begin
               if (go) begin
                  state_d        = S_RST;
                  run_idx_d      = '0;
                  timeout_err_d  = 1'b0;
                  started_seen_d = 1'b0;
               end
            end
            S_RST: begin
               if (timer_q == C_GAP_LAST) state_d = S_START;
            end
            S_START: begin
               if (phy_tx_done)                  state_d = S_NEXT;
               else if (timer_q == C_START_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
               // Done takes precedence over a simultaneous timeout.
               if (phy_tx_done) begin
                  state_d = S_NEXT;
               end else if (timer_q == C_TO_LAST) begin
                  state_d       = S_NEXT;
                  timeout_err_d = 1'b1;
               end
            end
            S_NEXT: begin
               if (run_idx_q == C_LAST_RUN) begin
                  state_d = S_FINISH;
               end else begin
                  state_d        = S_RST;
                  run_idx_d      = run_idx_q + RUN_W'(1);
                  started_seen_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (accept_en && phy_tx_started) started_seen_d = 1'b1;
      end

      if (state_d == S_NEXT) begin
         run_done_d    = 1'b1;
         run_samples_d = cnt_next;
      end
      if (state_d != state_q) timer_d = '0;

      arest_d    = (state_d == S_IDLE) || (state_d == S_RST) ||
                   (state_d == S_NEXT) || (state_d == S_FINISH);
      start_d    = (state_d == S_START);
      busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
      all_done_d = (state_d == S_FINISH);
   end

   // State and output registers; PHY reset asserted out of reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         run_idx_q      <= '0;
         run_samples_q  <= '0;
         run_done_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
         started_seen_q <= 1'b0;
         arest_q        <= 1'b1;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         all_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         run_idx_q      <= run_idx_d;
         run_samples_q  <= run_samples_d;
         run_done_q     <= run_done_d;
         timeout_err_q  <= timeout_err_d;
         started_seen_q <= started_seen_d;
         arest_q        <= arest_d;
         start_q        <= start_d;
         busy_q         <= busy_d;
         all_done_q     <= all_done_d;
      end
   end

   dot11_tx_iq_tap #(
      .IQ_W  (IQ_W),
      .RUN_W (RUN_W),
      .CNT_W (CNT_W)
   ) u_iq_tap (
      .clk          (clk),
      .rstn         (rstn),
      .accept_en    (accept_en),
      .cnt_clr      (cnt_clr),
      .run_idx      (run_idx_q),
      .iq_valid_in  (iq_valid_in),
      .i_in         (i_in),
      .q_in         (q_in),
      .iq_valid_out (iq_valid_out),
      .i_out        (i_out),
      .q_out        (q_out),
      .iq_run       (iq_run),
      .cnt_next     (cnt_next)
   );

   assign phy_tx_arest = arest_q;
   assign phy_tx_start = start_q;
   assign run_idx      = run_idx_q;
   assign run_done     = run_done_q;
   assign run_samples  = run_samples_q;
   assign busy         = busy_q;
   assign all_done     = all_done_q;
   assign timeout_err  = timeout_err_q;
   assign started_seen = started_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_dot11_tx_run_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot11_tx_run_seq
// Brief    : Directed self-checking bench for dot11_tx_run_seq. A second
//            instance with a 4-bit sample counter shares all stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot11_tx_run_seq;

   localparam int TO = 2140;

   logic        clk;
   logic        rstn;
   logic        go;
   logic        abort;
   logic        phy_tx_done;
   logic        phy_tx_started;
   logic        iq_valid_in;
   logic signed [15:0] i_in;
   logic signed [15:0] q_in;

   logic        phy_tx_arest, phy_tx_start, iq_valid_out;
   logic signed [15:0] i_out, q_out;
   logic [3:0]  iq_run, run_idx;
   logic        run_done, busy, all_done, timeout_err, started_seen;
   logic [15:0] run_samples;

   logic        arest_4, start_4, iq_valid_out_4;
   logic signed [15:0] i_out_4, q_out_4;
   logic [3:0]  iq_run_4, run_idx_4;
   logic        run_done_4, busy_4, all_done_4, timeout_err_4, started_seen_4;
   logic [3:0]  run_samples_4;

   int pass_cnt = 0;
   int total_cnt = 0;

   dot11_tx_run_seq dut (
      .clk(clk), .rstn(rstn), .go(go), .abort(abort),
      .phy_tx_arest(phy_tx_arest), .phy_tx_start(phy_tx_start),
      .phy_tx_done(phy_tx_done), .phy_tx_started(phy_tx_started),
      .iq_valid_in(iq_valid_in), .i_in(i_in), .q_in(q_in),
      .iq_valid_out(iq_valid_out), .i_out(i_out), .q_out(q_out),
      .iq_run(iq_run), .run_idx(run_idx), .run_done(run_done),
      .run_samples(run_samples), .busy(busy), .all_done(all_done),
      .timeout_err(timeout_err), .started_seen(started_seen)
   );

   dot11_tx_run_seq #(.CNT_W(4)) dut4 (
      .clk(clk), .rstn(rstn), .go(go), .abort(abort),
      .phy_tx_arest(arest_4), .phy_tx_start(start_4),
      .phy_tx_done(phy_tx_done), .phy_tx_started(phy_tx_started),
      .iq_valid_in(iq_valid_in), .i_in(i_in), .q_in(q_in),
      .iq_valid_out(iq_valid_out_4), .i_out(i_out_4), .q_out(q_out_4),
      .iq_run(iq_run_4), .run_idx(run_idx_4), .run_done(run_done_4),
      .run_samples(run_samples_4), .busy(busy_4), .all_done(all_done_4),
      .timeout_err(timeout_err_4), .started_seen(started_seen_4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Bounded wait for the START phase to appear.
   task automatic wait_start();
      int n;
      n = 0;
      while (phy_tx_start !== 1'b1 && n < 50) begin
         step(1);
         n++;
      end
      chk("start_seen", phy_tx_start, 1);
   endtask

   // PHY model: nsamp samples from the first START cycle, done on cycle done_at.
   task automatic phy_run(input int run, input int nsamp, input int done_at);
      int seen, bad;
      seen = 0;
      bad  = 0;
      wait_start();
      chk("run_idx", run_idx, run);
      for (int c = 1; c <= done_at; c++) begin
         iq_valid_in    = (c <= nsamp);
         i_in           = 16'(c);
         q_in           = 16'(-c);
         phy_tx_started = (c == 1);
         phy_tx_done    = (c == done_at);
         step(1);
         if (iq_valid_out === 1'b1) begin
            seen++;
            if (iq_run !== 4'(run) || i_out !== 16'(c) || q_out !== 16'(-c)) bad++;
         end
      end
      iq_valid_in    = 1'b0;
      phy_tx_done    = 1'b0;
      phy_tx_started = 1'b0;
      chk("run_done_pulse", run_done, 1);
      chk("run_samples", run_samples, nsamp);
      chk("sat_run_samples", run_samples_4, (nsamp > 15) ? 15 : nsamp);
      chk("iq_out_count", seen, nsamp);
      chk("iq_tag_data_bad", bad, 0);
      chk("started_seen", started_seen, 1);
   endtask

   // PHY that never completes: timeout exactly TO WAIT cycles after START.
   task automatic phy_timeout(input int run);
      wait_start();
      chk("to_run_idx", run_idx, run);
      step(5);
      chk("to_in_wait", phy_tx_start, 0);
      step(TO - 1);
      chk("to_not_yet", timeout_err, 0);
      chk("to_still_busy", run_done, 0);
      step(1);
      chk("to_set", timeout_err, 1);
      chk("to_run_done", run_done, 1);
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step(1);
      go = 1'b0;
   endtask

   initial begin
      int cnt;
      rstn = 1'b0; go = 1'b0; abort = 1'b0;
      phy_tx_done = 1'b0; phy_tx_started = 1'b0;
      iq_valid_in = 1'b0; i_in = '0; q_in = '0;
      step(3);

      // Reset values
      chk("rst_arest", phy_tx_arest, 1);
      chk("rst_start", phy_tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_all_done", all_done, 0);
      chk("rst_run_samples", run_samples, 0);
      chk("rst_timeout_err", timeout_err, 0);
      rstn = 1'b1;
      step(2);

      // Sequence A: three clean runs
      pulse_go();
      chk("go_busy", busy, 1);
      chk("go_arest", phy_tx_arest, 1);
      for (int r = 0; r < 3; r++) phy_run(r, 100, 300);
      step(1);
      chk("a_all_done", all_done, 1);
      chk("a_busy", busy, 0);
      chk("a_arest", phy_tx_arest, 1);
      chk("a_timeout_err", timeout_err, 0);

      // Sequence B: run 1 times out, run 2 proceeds
      pulse_go();
      chk("b_all_done_clr", all_done, 0);
      phy_run(0, 100, 300);
      phy_timeout(1);
      phy_run(2, 100, 300);
      step(1);
      chk("b_all_done", all_done, 1);
      chk("b_timeout_sticky", timeout_err, 1);

      // Sequence C: done coincident with timeout, then abort in run 1
      pulse_go();
      chk("c_timeout_clr", timeout_err, 0);
      phy_run(0, 100, TO + 5);
      chk("c_done_wins", timeout_err, 0);
      wait_start();
      chk("c_run1", run_idx, 1);
      iq_valid_in = 1'b1;
      i_in = 16'sd9;
      step(10);
      iq_valid_in = 1'b0;
      step(20);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("abort_arest", phy_tx_arest, 1);
      chk("abort_busy", busy, 0);
      chk("abort_start", phy_tx_start, 0);
      chk("abort_no_done", run_done, 0);
      chk("abort_samples_hold", run_samples, 100);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (run_done !== 1'b0 || busy !== 1'b0) cnt++;
      end
      chk("abort_stays_idle", cnt, 0);

      // Sequence D: samples in RST dropped, saturation, async reset in START
      pulse_go();
      iq_valid_in = 1'b1;
      i_in = 16'sd7;
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         if (iq_valid_out !== 1'b0) cnt++;
      end
      iq_valid_in = 1'b0;
      chk("rst_samples_dropped", cnt, 0);
      phy_run(0, 20, 300);
      wait_start();
      step(2);
      rstn = 1'b0;
      #1;
      chk("async_arest", phy_tx_arest, 1);
      chk("async_start", phy_tx_start, 0);
      chk("async_busy", busy, 0);
      chk("async_run_idx", run_idx, 0);
      chk("async_run_samples", run_samples, 0);
      #1;
      rstn = 1'b1;
      step(1);
      pulse_go();
      chk("restart_busy", busy, 1);
      phy_run(0, 100, 300);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
